// File: rtl/det3_pkg.sv
// det3_pkg: shared definitions for the sequential 3x3 determinant engine.
//
// Contents:
//   W, NUM_ELEM, NUM_STEPS, NUM_TERMS   sizing constants
//   state_t                             FSM state encoding (LOAD/CALC/DONE)
//   SAT_MAX / SAT_MIN                   accumulator clamp limits
//   term_x/term_y/term_z/term_neg       Sarrus term operand index tables
//   clamp_sum                           9-bit sum -> 8-bit saturated result
//
// Elements are stored row-major: index = 3*row + col, so m00=0, m11=4, m22=8.
package det3_pkg;

  localparam int W         = 8;
  localparam int NUM_ELEM  = 9;
  localparam int NUM_STEPS = 12;
  localparam int NUM_TERMS = 6;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [W-1:0] SAT_MAX = 8'h7F;  // +127
  localparam logic [W-1:0] SAT_MIN = 8'h80;  // -128

  // Term k is sign * m[x] * m[y] * m[z]; the first multiply pairs x and y,
  // the second multiplies that partial product by z.
  //   k0: +m00*m11*m22   k1: +m01*m12*m20   k2: +m02*m10*m21
  //   k3: -m02*m11*m20   k4: -m00*m12*m21   k5: -m01*m10*m22
  function automatic logic [3:0] term_x(input logic [2:0] k);
    case (k)
      3'd0:    term_x = 4'd0;
      3'd1:    term_x = 4'd1;
      3'd2:    term_x = 4'd2;
      3'd3:    term_x = 4'd2;
      3'd4:    term_x = 4'd0;
      3'd5:    term_x = 4'd1;
      default: term_x = 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] term_y(input logic [2:0] k);
    case (k)
      3'd0:    term_y = 4'd4;
      3'd1:    term_y = 4'd5;
      3'd2:    term_y = 4'd3;
      3'd3:    term_y = 4'd4;
      3'd4:    term_y = 4'd5;
      3'd5:    term_y = 4'd3;
      default: term_y = 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] term_z(input logic [2:0] k);
    case (k)
      3'd0:    term_z = 4'd8;
      3'd1:    term_z = 4'd6;
      3'd2:    term_z = 4'd7;
      3'd3:    term_z = 4'd6;
      3'd4:    term_z = 4'd7;
      3'd5:    term_z = 4'd8;
      default: term_z = 4'd0;
    endcase
  endfunction

  // 1 = the term is subtracted from the accumulator.
  function automatic logic term_neg(input logic [2:0] k);
    case (k)
      3'd3, 3'd4, 3'd5: term_neg = 1'b1;
      default:          term_neg = 1'b0;
    endcase
  endfunction

  // A 9-bit sign-extended sum has overflowed the 8-bit range when its top
  // two bits differ; bit 8 then carries the true sign of the result.
  function automatic logic [W-1:0] clamp_sum(input logic [W:0] sum);
    if (sum[W] != sum[W-1]) begin
      clamp_sum = sum[W] ? SAT_MIN : SAT_MAX;
    end else begin
      clamp_sum = sum[W-1:0];
    end
  endfunction

endpackage

// File: rtl/s8_mul_ovf.sv
// s8_mul_ovf: combinational signed 8x8 multiply returning the low byte of the
// 16-bit product plus a flag that is set when the product does not fit in a
// signed byte (upper byte differs from the sign-extension of bit 7).
//
// Ports:
//   a, b     in   W   signed operands
//   prod_lo  out  W   low W bits of a*b (wrapped result)
//   ovf      out  1   product overflowed the signed W-bit range
module s8_mul_ovf
  import det3_pkg::*;
(
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic        [W-1:0] prod_lo,
  output logic                ovf
);

  logic signed [2*W-1:0] full;

  always_comb begin
    full    = a * b;
    prod_lo = full[W-1:0];
    ovf     = (full[2*W-1:W] != {W{full[W-1]}});
  end

endmodule

// File: rtl/det3_seq.sv
// det3_seq: sequential 3x3 signed determinant engine.
//
// Nine signed elements are streamed in row-major order, then the six Sarrus
// terms are evaluated with a single shared multiplier over 12 cycles (two
// multiplies per term), accumulating into an 8-bit register. The result and
// a sticky overflow flag are held until the consumer takes them.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; valid, once raised by a producer, is expected to stay up with
// stable data until that edge. in_ready and out_valid depend only on the
// FSM state (and rst), never on in_valid or out_ready.
//
// Ports:
//   clk        in   1   clock, rising edge
//   rst        in   1   synchronous reset, active-high
//   in_valid   in   1   element present on in_data
//   in_ready   out  1   element accepted this cycle when in_valid is high
//   in_data    in   W   signed element, order m00,m01,m02,m10,...,m22
//   out_valid  out  1   det/ovf valid
//   out_ready  in   1   consumer accepts the result
//   det        out  W   signed determinant (wrapped, or saturated)
//   ovf        out  1   sticky overflow for the current computation
//   fsm_state  out  2   current FSM state, for observation
//
// Build option: define DET3_SATURATE_EN to clamp each accumulate to
// +127/-128 on overflow instead of wrapping. Multiply overflow always wraps.
module det3_seq
  import det3_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] det,
  output logic         ovf,
  output state_t       fsm_state
);

  localparam logic [3:0] LAST_IDX  = 4'(NUM_ELEM - 1);
  localparam logic [3:0] LAST_STEP = 4'(NUM_STEPS - 1);

  state_t state;
  state_t state_next;

  logic [W-1:0] elem [NUM_ELEM];
  logic [3:0]   idx;
  logic [3:0]   step;
  logic [W-1:0] acc;
  logic [W-1:0] p;

  logic [2:0]   term;
  logic [W-1:0] mul_a;
  logic [W-1:0] mul_b;
  logic [W-1:0] mul_lo;
  logic         mul_ovf;
  logic [W:0]   acc_ext;
  logic [W:0]   t_ext;
  logic [W:0]   sum;
  logic         add_ovf;
  logic [W-1:0] acc_next;

  logic accept;
  logic last_accept;

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_LOAD;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      ST_LOAD: if (last_accept)                  state_next = ST_CALC;
      ST_CALC: if (step == LAST_STEP)            state_next = ST_DONE;
      ST_DONE: if (out_valid && out_ready)       state_next = ST_LOAD;
      default:                                   state_next = ST_LOAD;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs (state-derived only)
  // ---------------------------------------------------------------------
  always_comb begin
    in_ready  = (state == ST_LOAD) && !rst;
    out_valid = (state == ST_DONE);
  end

  assign fsm_state   = state;
  assign accept      = in_valid && in_ready;
  assign last_accept = accept && (idx == LAST_IDX);

  // ---------------------------------------------------------------------
  // Shared multiplier: even steps form m[x]*m[y], odd steps multiply the
  // held partial product p by m[z].
  // ---------------------------------------------------------------------
  assign term = step[3:1];

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    if (!step[0]) begin
      mul_a = elem[term_x(term)];
      mul_b = elem[term_y(term)];
    end else begin
      mul_a = p;
      mul_b = elem[term_z(term)];
    end
  end

  s8_mul_ovf u_mul (
    .a       (mul_a),
    .b       (mul_b),
    .prod_lo (mul_lo),
    .ovf     (mul_ovf)
  );

  // ---------------------------------------------------------------------
  // Accumulate in 9 bits so both add and subtract overflow show up as a
  // disagreement between bits 8 and 7.
  // ---------------------------------------------------------------------
  always_comb begin
    acc_ext = {acc[W-1], acc};
    t_ext   = {mul_lo[W-1], mul_lo};
    if (term_neg(term)) begin
      sum = acc_ext - t_ext;
    end else begin
      sum = acc_ext + t_ext;
    end
    add_ovf = (sum[W] != sum[W-1]);
`ifdef DET3_SATURATE_EN
    acc_next = clamp_sum(sum);
`else
    acc_next = sum[W-1:0];
`endif
  end

  // ---------------------------------------------------------------------
  // Element storage. Not reset: a partial matrix is simply overwritten by
  // the next load, and writes are already blocked while rst is high.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (accept) begin
      elem[idx] <= in_data;
    end
  end

  // ---------------------------------------------------------------------
  // Datapath control registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      idx  <= '0;
      step <= '0;
      acc  <= '0;
      p    <= '0;
      ovf  <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (accept) begin
            if (idx == LAST_IDX) begin
              // Starting a fresh computation: clear the previous result.
              idx  <= '0;
              step <= '0;
              acc  <= '0;
              ovf  <= 1'b0;
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
        ST_CALC: begin
          step <= (step == LAST_STEP) ? 4'd0 : step + 4'd1;
          if (!step[0]) begin
            p   <= mul_lo;
            ovf <= ovf | mul_ovf;
          end else begin
            acc <= acc_next;
            ovf <= ovf | mul_ovf | add_ovf;
          end
        end
        default: begin
          // DONE: result held stable until the output handshake.
        end
      endcase
    end
  end

  assign det = acc;

endmodule

// File: tb/tb_det3_seq.sv
// Directed bench for det3_seq with a result scoreboard.
module tb_det3_seq;
  import det3_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [7:0]   in_data = '0;
  logic         out_ready = 1'b0;
  logic         in_ready;
  logic         out_valid;
  logic [7:0]   det;
  logic         ovf;
  state_t       fsm_state;

  // {ovf, det}
  logic [8:0] exp_q[$];

  int n_checks = 0;
  int n_fails  = 0;

  // ------------------------------------------------------------ clock/reset
  always #5 clk = ~clk;

  det3_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .det       (det),
    .ovf       (ovf),
    .fsm_state (fsm_state)
  );

  // ------------------------------------------------------------ helpers
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0][7:0] mat(input int a, input int b, input int c,
                                          input int d, input int e, input int f,
                                          input int g, input int h, input int i);
    logic [8:0][7:0] r;
    r[0] = 8'(a); r[1] = 8'(b); r[2] = 8'(c);
    r[3] = 8'(d); r[4] = 8'(e); r[5] = 8'(f);
    r[6] = 8'(g); r[7] = 8'(h); r[8] = 8'(i);
    return r;
  endfunction

  // ------------------------------------------------------------ drivers
  task automatic send_elem(input logic [7:0] v, input int gap);
    int   n;
    logic took;
    repeat (gap) tick;
    in_valid = 1'b1;
    in_data  = v;
    n    = 0;
    took = 1'b0;
    while (!took && n < 50) begin
      took = in_ready;
      tick;
      n++;
    end
    in_valid = 1'b0;
    check("elem_accepted", took, 1);
  endtask

  // Leaves the bench #1 after the edge that accepted the 9th element.
  task automatic load_matrix(input logic [8:0][7:0] m, input int max_gap,
                             input logic push, input logic [8:0] exp);
    for (int i = 0; i < 9; i++) begin
      send_elem(m[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    end
    if (push) exp_q.push_back(exp);
  endtask

  // exp_lat < 0 skips the latency comparison.
  task automatic collect(input string tag, input int exp_lat);
    int         n;
    logic [8:0] e;
    n = 0;
    while (!out_valid && n < 100) begin
      tick;
      n++;
    end
    check({tag, "_out_valid"}, out_valid, 1);
    if (exp_lat >= 0) check({tag, "_latency"}, n, exp_lat);
    check({tag, "_queue_nonempty"}, (exp_q.size() > 0), 1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
    check({tag, "_det"}, det, e[7:0]);
    check({tag, "_ovf"}, ovf, e[8]);
    out_ready = 1'b1;
    check({tag, "_in_ready_handshake"}, in_ready, 0);
    tick;
    out_ready = 1'b0;
    check({tag, "_out_valid_drop"}, out_valid, 0);
    check({tag, "_in_ready_rise"}, in_ready, 1);
  endtask

  // ------------------------------------------------------------ stimulus
  initial begin
    int         a[9];
    int         d_exact;
    logic [8:0] hold_exp;

    // Reset
    rst = 1'b1;
    repeat (3) tick;
    check("rst_out_valid", out_valid, 0);
    check("rst_det", det, 0);
    check("rst_ovf", ovf, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_state", fsm_state, ST_LOAD);
    rst = 1'b0;
    tick;
    check("post_rst_in_ready", in_ready, 1);

    // Identity, back-to-back elements, latency 12 edges after acceptance
    load_matrix(mat(1, 0, 0, 0, 1, 0, 0, 0, 1), 0, 1'b1, {1'b0, 8'd1});
    collect("identity", 12);

    // Mixed signs with random gaps -> 49
    load_matrix(mat(2, -3, 1, 2, 0, -1, 1, 4, 5), 3, 1'b1, {1'b0, 8'd49});
    collect("gapped", 12);

    // 16*16 multiply wraps to zero -> det 0, ovf set
    load_matrix(mat(16, 0, 0, 0, 16, 0, 0, 0, 1), 0, 1'b1, {1'b1, 8'd0});
    collect("mul_ovf", 12);

    // 100 + 50 accumulate overflow
`ifdef DET3_SATURATE_EN
    load_matrix(mat(10, 5, 0, 0, 10, 5, 2, 0, 1), 1, 1'b1, {1'b1, 8'd127});
`else
    load_matrix(mat(10, 5, 0, 0, 10, 5, 2, 0, 1), 1, 1'b1, {1'b1, 8'h96});
`endif
    collect("add_ovf", 12);

    // Random small matrices: exact cofactor determinant always fits in 8 bits
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 9; i++) a[i] = int'($urandom_range(0, 4)) - 2;
      d_exact = a[0] * (a[4] * a[8] - a[5] * a[7])
              - a[1] * (a[3] * a[8] - a[5] * a[6])
              + a[2] * (a[3] * a[7] - a[4] * a[6]);
      load_matrix(mat(a[0], a[1], a[2], a[3], a[4], a[5], a[6], a[7], a[8]),
                  2, 1'b1, {1'b0, 8'(d_exact)});
      collect("random", 12);
    end

    // Back-pressure: hold out_ready low with in_valid high for 5 cycles
    load_matrix(mat(2, 0, 0, 0, 2, 0, 0, 0, 2), 0, 1'b1, {1'b0, 8'd8});
    hold_exp = exp_q[0];
    repeat (12) tick;
    in_valid = 1'b1;
    in_data  = 8'h55;
    for (int i = 0; i < 5; i++) begin
      check("hold_out_valid", out_valid, 1);
      check("hold_det", det, hold_exp[7:0]);
      check("hold_ovf", ovf, hold_exp[8]);
      check("hold_in_ready", in_ready, 0);
      tick;
    end
    in_valid = 1'b0;
    collect("hold", -1);
    load_matrix(mat(1, 2, 3, 0, 1, 4, 5, 6, 0), 0, 1'b1, {1'b0, 8'd1});
    collect("after_hold", 12);

    // Reset in the middle of CALC (step 5), with ovf already set by step 0
    load_matrix(mat(16, 0, 0, 0, 16, 0, 0, 0, 1), 0, 1'b0, 9'h0);
    repeat (5) tick;
    check("mid_calc_state", fsm_state, ST_CALC);
    check("mid_calc_ovf", ovf, 1);
    rst = 1'b1;
    tick;
    check("calc_rst_state", fsm_state, ST_LOAD);
    check("calc_rst_out_valid", out_valid, 0);
    check("calc_rst_ovf", ovf, 0);
    check("calc_rst_in_ready", in_ready, 0);
    rst = 1'b0;
    tick;
    load_matrix(mat(1, 0, 0, 0, 1, 0, 0, 0, 1), 0, 1'b1, {1'b0, 8'd1});
    collect("post_calc_rst", 12);

    check("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/det3_seq.md
# det3_seq

Sequential 3×3 signed determinant engine for the coprocessor's determinant path. Accepts nine signed 8-bit matrix elements over a valid/ready stream. Computes the Sarrus expansion with one shared signed 8×8 multiplier-with-overflow, using two multiplies per term. Returns an 8-bit signed determinant plus a sticky overflow flag over a valid/ready output.

## Interface
- W, 8, element/result width; only 8 is supported.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  element present on in_data.
- in_ready  out  1  block accepts an element; equals (state==LOAD) && !rst.
- in_data  in  W  signed element, row-major order m00,m01,m02,m10,…,m22.
- out_valid  out  1  det/ovf valid.
- out_ready  in  1  consumer accepts the result.
- det  out  W  signed determinant (wrapped, or saturated under macro).
- ovf  out  1  sticky: any multiply or accumulate overflow in this computation.

## Operation
- FSM states LOAD → CALC → DONE → LOAD.
- LOAD:
  - Each in_valid&&in_ready writes in_data to element reg[idx] and increments idx (0..8).
  - Gaps in in_valid are allowed.
  - Accepting idx==8 moves to CALC. At that point: idx=0, step=0, acc=0, ovf=0.
- CALC: 12 cycles, step 0..11; term k = step>>1.
  - Terms in order: +m00·m11·m22, +m01·m12·m20, +m02·m10·m21, −m02·m11·m20, −m00·m12·m21, −m01·m10·m22.
  - Even step: p ← mul(x_k, y_k), where mul returns low 8 bits of the 16-bit signed product. Flag set if bits[15:8] ≠ sign-extension of bit 7.
  - Odd step: t = mul(p, z_k). Then acc ← acc ± t, computed as a 9-bit sign-extended sum. Add overflow when sum[8] ≠ sum[7].
  - ovf |= every multiply flag and add flag.
  - Step 11 moves to DONE.
- DONE:
  - out_valid=1; det=acc and ovf are held stable.
  - in_ready=0; in_valid is ignored.
  - out_valid&&out_ready returns to LOAD on the next cycle.
- rst at any time, including mid-LOAD or mid-CALC:
  - Next state is LOAD; idx, step, acc, p and ovf are cleared.
  - Partial matrix is discarded. Element registers need not clear.
- Reset values: out_valid=0, det=0, ovf=0, in_ready=0 while rst is high, and 1 the cycle after rst drops.

## Timing
- Element acceptance: one per cycle maximum.
- 9th element accepted in cycle c → CALC during cycles c+1..c+12 → out_valid=1 from cycle c+13.
- Minimum matrix-to-matrix period: 9 + 12 + 1 = 22 cycles, with out_ready held high.
- out_valid stays high until handshake.
- In the handshake cycle, in_ready is still 0. in_ready rises the following cycle.
- All outputs are registered or derived only from state; there is no combinational in→out path.

## Configuration
- DET3_SATURATE_EN defined:
  - Each accumulate clamps on overflow: +127 if the 9-bit sum is positive, −128 if negative. ovf is still set.
  - Multiply overflow still wraps.
- Undefined: accumulate wraps modulo 256, and ovf is set.

## Structure
- det3_pkg holds:
  - W, NUM_ELEM=9, NUM_STEPS=12.
  - State encoding.
  - Per-term operand index tables x_k/y_k/z_k and sign bit.
  - SAT_MAX=127, SAT_MIN=−128.
- One sub-module, s8_mul_ovf: combinational signed 8×8 → low byte + overflow flag. Instantiated once and muxed by step.

## Test plan
- Identity matrix → det=1, ovf=0, out_valid at c+13.
- [[2,−3,1],[2,0,−1],[1,4,5]] with random in_valid gaps → det=49, ovf=0.
- diag(16,16,1) → 16·16 wraps to 0 → det=0, ovf=1 (same under macro).
- [[10,5,0],[0,10,5],[2,0,1]] → 100+50 accumulate overflow:
  - Without macro: det=−106, ovf=1.
  - With DET3_SATURATE_EN: det=127, ovf=1.
- Hold out_ready=0 for 5 cycles after out_valid with in_valid=1 → det/ovf stable, in_ready=0, no elements consumed. Release → next matrix loads correctly.
- Assert rst during CALC step 5 → LOAD next cycle, out_valid=0, ovf=0. Then load identity → det=1.
